// File: rtl/wordle_pkg.sv
// Shared colour codes, blank fill character and scorer FSM states.
package wordle_pkg;

  localparam logic [1:0] COL_EMPTY   = 2'b00;
  localparam logic [1:0] COL_ABSENT  = 2'b01;
  localparam logic [1:0] COL_PRESENT = 2'b10;
  localparam logic [1:0] COL_CORRECT = 2'b11;

  localparam logic [7:0] BLANK_CHAR = 8'h20;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_GREEN,
    ST_YELLOW,
    ST_COMMIT,
    ST_OVER
  } state_t;

endpackage

// File: rtl/wordle_letter_match.sv
// Finds the lowest unused answer position holding a given letter.
module wordle_letter_match #(
  parameter int WORD_LEN = 5,
  parameter int LETTER_W = 8
) (
  input  logic [LETTER_W-1:0]          letter,
  input  logic [WORD_LEN*LETTER_W-1:0] answer,
  input  logic [WORD_LEN-1:0]          used,
  output logic                         hit,
  output logic [WORD_LEN-1:0]          hit_pos
);

  // Bit j of used/hit_pos refers to answer letter j (letter 0 in the MSBs).
  always_comb begin
    hit     = 1'b0;
    hit_pos = '0;
    for (int unsigned j = 0; j < WORD_LEN; j++) begin
      if (!hit && !used[j] &&
          answer[(WORD_LEN-1-j)*LETTER_W +: LETTER_W] == letter) begin
        hit        = 1'b1;
        hit_pos[j] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/wordle_guess_scorer.sv
// Two-pass Wordle scorer (exact matches, then present-elsewhere) with
// per-row guess/colour history and sticky win/lose flags.
module wordle_guess_scorer
  import wordle_pkg::*;
#(
  parameter int WORD_LEN    = 5,
  parameter int MAX_GUESSES = 6,
  parameter int LETTER_W    = 8,
  localparam int IDX_W      = $clog2(WORD_LEN),
  localparam int CNT_W      = $clog2(MAX_GUESSES + 1)
) (
  input  logic                                  Clk,
  input  logic                                  reset_n,
  input  logic                                  clr,
  input  logic                                  start,
  input  logic [WORD_LEN*LETTER_W-1:0]          guess,
  input  logic [WORD_LEN*LETTER_W-1:0]          answer,
  output logic                                  ready,
  output logic                                  done,
  output logic                                  win,
  output logic                                  lose,
  output logic [CNT_W-1:0]                      guess_cnt,
  output logic [MAX_GUESSES*WORD_LEN*LETTER_W-1:0] hist_letters,
  output logic [MAX_GUESSES*WORD_LEN*2-1:0]     hist_colors
);

  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(WORD_LEN - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(MAX_GUESSES);
  localparam logic [MAX_GUESSES*WORD_LEN*LETTER_W-1:0] BLANK_HIST =
    {(MAX_GUESSES*WORD_LEN){LETTER_W'(BLANK_CHAR)}};

  state_t                                       state_q, state_d;
  logic [IDX_W-1:0]                             idx_q, idx_d;
  logic                                         commit_ph_q, commit_ph_d;
  logic [0:WORD_LEN-1][LETTER_W-1:0]            g_q, g_d;
  logic [0:WORD_LEN-1][LETTER_W-1:0]            a_q, a_d;
  logic [WORD_LEN-1:0]                          used_q, used_d;
  logic [0:WORD_LEN-1][1:0]                     scratch_q, scratch_d;
  logic [0:MAX_GUESSES-1][0:WORD_LEN-1][LETTER_W-1:0] hist_let_q, hist_let_d;
  logic [0:MAX_GUESSES-1][0:WORD_LEN-1][1:0]    hist_col_q, hist_col_d;
  logic [CNT_W-1:0]                             guess_cnt_q, guess_cnt_d;
  logic                                         done_q, done_d;
  logic                                         win_q, win_d;
  logic                                         lose_q, lose_d;
  logic                                         ready_q, ready_d;

  logic                                         hit;
  logic [WORD_LEN-1:0]                          hit_pos;
  logic [CNT_W-1:0]                             cnt_inc;

  wordle_letter_match #(
    .WORD_LEN (WORD_LEN),
    .LETTER_W (LETTER_W)
  ) u_match (
    .letter  (g_q[idx_q]),
    .answer  (a_q),
    .used    (used_q),
    .hit     (hit),
    .hit_pos (hit_pos)
  );

  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    commit_ph_d = commit_ph_q;
    g_d         = g_q;
    a_d         = a_q;
    used_d      = used_q;
    scratch_d   = scratch_q;
    hist_let_d  = hist_let_q;
    hist_col_d  = hist_col_q;
    guess_cnt_d = guess_cnt_q;
    done_d      = 1'b0;
    win_d       = win_q;
    lose_d      = lose_q;
    cnt_inc     = (guess_cnt_q == CNT_MAX) ? guess_cnt_q : guess_cnt_q + 1'b1;

    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          g_d       = guess;
          a_d       = answer;
          used_d    = '0;
          scratch_d = '0;
          idx_d     = '0;
          state_d   = ST_GREEN;
        end
      end
      ST_GREEN: begin
        if (g_q[idx_q] == a_q[idx_q]) begin
          scratch_d[idx_q] = COL_CORRECT;
          used_d[idx_q]    = 1'b1;
        end else begin
          scratch_d[idx_q] = COL_ABSENT;
        end
        if (idx_q == IDX_LAST) begin
          idx_d   = '0;
          state_d = ST_YELLOW;
        end else begin
          idx_d = idx_q + 1'b1;
        end
      end
      ST_YELLOW: begin
        if (scratch_q[idx_q] != COL_CORRECT && hit) begin
          scratch_d[idx_q] = COL_PRESENT;
          used_d           = used_q | hit_pos;
        end
        if (idx_q == IDX_LAST) begin
          idx_d       = '0;
          commit_ph_d = 1'b0;
          state_d     = ST_COMMIT;
        end else begin
          idx_d = idx_q + 1'b1;
        end
      end
      ST_COMMIT: begin
        // Two-cycle commit: history, count, flags and done all land together
        // 2*WORD_LEN+2 cycles after the accepting edge.
        if (!commit_ph_q) begin
          commit_ph_d = 1'b1;
        end else begin
          commit_ph_d             = 1'b0;
          hist_let_d[guess_cnt_q] = g_q;
          hist_col_d[guess_cnt_q] = scratch_q;
          guess_cnt_d             = cnt_inc;
          done_d                  = 1'b1;
          if (scratch_q == '1) begin
            win_d   = 1'b1;
            state_d = ST_OVER;
          end else if (cnt_inc == CNT_MAX) begin
            lose_d  = 1'b1;
            state_d = ST_OVER;
          end else begin
            state_d = ST_IDLE;
          end
        end
      end
      ST_OVER: ;
      default: state_d = ST_IDLE;
    endcase

    if (clr) begin
      state_d     = ST_IDLE;
      idx_d       = '0;
      commit_ph_d = 1'b0;
      used_d      = '0;
      scratch_d   = '0;
      hist_let_d  = BLANK_HIST;
      hist_col_d  = '0;
      guess_cnt_d = '0;
      done_d      = 1'b0;
      win_d       = 1'b0;
      lose_d      = 1'b0;
    end

    ready_d = (state_d == ST_IDLE);
  end

  always_ff @(posedge Clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= ST_IDLE;
      idx_q       <= '0;
      commit_ph_q <= 1'b0;
      g_q         <= '0;
      a_q         <= '0;
      used_q      <= '0;
      scratch_q   <= '0;
      hist_let_q  <= BLANK_HIST;
      hist_col_q  <= '0;
      guess_cnt_q <= '0;
      done_q      <= 1'b0;
      win_q       <= 1'b0;
      lose_q      <= 1'b0;
      ready_q     <= 1'b1;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      commit_ph_q <= commit_ph_d;
      g_q         <= g_d;
      a_q         <= a_d;
      used_q      <= used_d;
      scratch_q   <= scratch_d;
      hist_let_q  <= hist_let_d;
      hist_col_q  <= hist_col_d;
      guess_cnt_q <= guess_cnt_d;
      done_q      <= done_d;
      win_q       <= win_d;
      lose_q      <= lose_d;
      ready_q     <= ready_d;
    end
  end

  assign ready        = ready_q;
  assign done         = done_q;
  assign win          = win_q;
  assign lose         = lose_q;
  assign guess_cnt    = guess_cnt_q;
  assign hist_letters = hist_let_q;
  assign hist_colors  = hist_col_q;

endmodule

// File: tb/tb_wordle_guess_scorer.sv
// Self-checking bench for wordle_guess_scorer: directed cases plus random games
// against a letter-count reference scorer.
module tb_wordle_guess_scorer;

  localparam int WL = 5;
  localparam int MG = 6;
  localparam int LW = 8;
  localparam int CW = $clog2(MG + 1);
  localparam int LAT = 2*WL + 2;

  logic                 Clk = 1'b0;
  logic                 reset_n = 1'b0;
  logic                 clr = 1'b0;
  logic                 start = 1'b0;
  logic [WL*LW-1:0]     guess = '0;
  logic [WL*LW-1:0]     answer = '0;
  logic                 ready, done, win, lose;
  logic [CW-1:0]        guess_cnt;
  logic [MG*WL*LW-1:0]  hist_letters;
  logic [MG*WL*2-1:0]   hist_colors;

  int n_total = 0;
  int n_bad   = 0;

  logic [MG*WL*LW-1:0]  exp_hl;
  logic [MG*WL*2-1:0]   exp_hc;
  int                   exp_cnt;
  logic                 exp_win, exp_lose;

  wordle_guess_scorer #(
    .WORD_LEN    (WL),
    .MAX_GUESSES (MG),
    .LETTER_W    (LW)
  ) dut (
    .Clk          (Clk),
    .reset_n      (reset_n),
    .clr          (clr),
    .start        (start),
    .guess        (guess),
    .answer       (answer),
    .ready        (ready),
    .done         (done),
    .win          (win),
    .lose         (lose),
    .guess_cnt    (guess_cnt),
    .hist_letters (hist_letters),
    .hist_colors  (hist_colors)
  );

  always #5 Clk = ~Clk;

  task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Reference: greens first, then yellows drawn from a per-letter pool of
  // the answer letters that were not matched exactly.
  function automatic logic [2*WL-1:0] ref_score(input logic [WL*LW-1:0] g, input logic [WL*LW-1:0] a);
    logic [7:0]   gl [WL];
    logic [7:0]   al [WL];
    logic [1:0]   c  [WL];
    int           pool [256];
    logic [2*WL-1:0] r;
    for (int k = 0; k < 256; k++) pool[k] = 0;
    for (int i = 0; i < WL; i++) begin
      gl[i] = g[LW*(WL-1-i) +: LW];
      al[i] = a[LW*(WL-1-i) +: LW];
    end
    for (int i = 0; i < WL; i++) begin
      if (gl[i] == al[i]) c[i] = 2'd3;
      else begin
        c[i] = 2'd1;
        pool[al[i]] = pool[al[i]] + 1;
      end
    end
    for (int i = 0; i < WL; i++) begin
      if (c[i] != 2'd3 && pool[gl[i]] > 0) begin
        c[i] = 2'd2;
        pool[gl[i]] = pool[gl[i]] - 1;
      end
    end
    for (int i = 0; i < WL; i++) r[2*(WL-1-i) +: 2] = c[i];
    return r;
  endfunction

  function automatic logic [WL*LW-1:0] rand_word();
    logic [WL*LW-1:0] w;
    for (int i = 0; i < WL; i++) w[LW*i +: LW] = 8'h41 + 8'($urandom_range(0, 3));
    return w;
  endfunction

  task automatic model_reset();
    exp_hl   = {(MG*WL){8'h20}};
    exp_hc   = '0;
    exp_cnt  = 0;
    exp_win  = 1'b0;
    exp_lose = 1'b0;
  endtask

  task automatic check_all(input string tag);
    check({tag, ".cnt"},  256'(guess_cnt), 256'(exp_cnt));
    check({tag, ".win"},  256'(win),  256'(exp_win));
    check({tag, ".lose"}, 256'(lose), 256'(exp_lose));
    check({tag, ".ready"}, 256'(ready), 256'(!(exp_win || exp_lose)));
    check({tag, ".hl"},   256'(hist_letters), 256'(exp_hl));
    check({tag, ".hc"},   256'(hist_colors),  256'(exp_hc));
  endtask

  // Submit one guess; a second start pulse mid-scoring must be ignored.
  task automatic submit(input string tag, input logic [WL*LW-1:0] g,
                        input logic [WL*LW-1:0] a, input bit accept_exp);
    int n;
    int dones;
    logic [2*WL-1:0] col;
    @(negedge Clk);
    start = 1'b1; guess = g; answer = a;
    @(negedge Clk);
    start = 1'b0; guess = rand_word(); answer = rand_word();
    n = 0; dones = 0;
    for (int k = 1; k <= 40; k++) begin
      @(posedge Clk); #1;
      start = (k == 3);
      if (done) begin
        dones++;
        if (n == 0) n = k;
        if (accept_exp) break;
      end
    end
    start = 1'b0;
    if (accept_exp) begin
      col = ref_score(g, a);
      exp_hl[(MG-1-exp_cnt)*WL*LW +: WL*LW] = g;
      exp_hc[(MG-1-exp_cnt)*WL*2 +: WL*2]   = col;
      exp_cnt++;
      if (col == '1) exp_win = 1'b1;
      else if (exp_cnt == MG) exp_lose = 1'b1;
      check({tag, ".lat"}, 256'(n), 256'(LAT));
      check_all(tag);
      @(posedge Clk); #1;
      check({tag, ".pulse"}, 256'(done), 256'(0));
    end else begin
      check({tag, ".nodone"}, 256'(dones), 256'(0));
      check_all(tag);
    end
  endtask

  task automatic do_clr();
    @(negedge Clk); clr = 1'b1;
    @(negedge Clk); clr = 1'b0;
    model_reset();
  endtask

  initial begin
    logic [WL*LW-1:0] ans;
    int tries;
    model_reset();
    #12 reset_n = 1'b1;
    @(negedge Clk);
    check_all("reset");
    check("reset.done", 256'(done), 256'(0));

    submit("crane", "CRANE", "CRANE", 1'b1);
    check("crane.row0", 256'(hist_colors[MG*WL*2-1 -: 10]), 256'(10'b1111111111));
    submit("over_ign", "ABCDE", "CRANE", 1'b0);

    do_clr();
    check_all("clr");
    submit("eerie", "EERIE", "CRANE", 1'b1);
    check("eerie.row0", 256'(hist_colors[MG*WL*2-1 -: 10]), 256'(10'b0101100111));

    do_clr();
    submit("babes", "BABES", "ABBEY", 1'b1);
    check("babes.row0", 256'(hist_colors[MG*WL*2-1 -: 10]), 256'(10'b1010111101));

    // Abort the second guess with clr four cycles into scoring.
    @(negedge Clk); start = 1'b1; guess = "HELLO"; answer = "WORLD";
    @(negedge Clk); start = 1'b0;
    repeat (3) @(negedge Clk);
    clr = 1'b1;
    @(negedge Clk); clr = 1'b0;
    model_reset();
    check_all("abort");
    tries = 0;
    for (int k = 0; k < 30; k++) begin
      @(posedge Clk); #1;
      if (done) tries++;
    end
    check("abort.nodone", 256'(tries), 256'(0));
    check_all("abort2");

    for (int k = 0; k < MG; k++) submit("zzz", "ZZZZZ", "CRANE", 1'b1);
    check("zzz.lose", 256'(lose), 256'(1));
    submit("zzz7", "ZZZZZ", "CRANE", 1'b0);

    // Async reset in the middle of the yellow pass.
    do_clr();
    submit("pre_rst", "NACRE", "CRANE", 1'b1);
    @(negedge Clk); start = 1'b1; guess = "RANCE"; answer = "CRANE";
    @(negedge Clk); start = 1'b0;
    repeat (6) @(negedge Clk);
    #2 reset_n = 1'b0;
    #1;
    model_reset();
    check_all("async_rst");
    check("async_rst.done", 256'(done), 256'(0));
    #1 reset_n = 1'b1;
    submit("post_rst", "RANCE", "CRANE", 1'b1);

    for (int game = 0; game < 4; game++) begin
      do_clr();
      ans = rand_word();
      tries = 0;
      while (!(exp_win || exp_lose) && tries < MG + 1) begin
        submit("rand", rand_word(), ans, 1'b1);
        tries++;
      end
      submit("rand_over", rand_word(), ans, 1'b0);
    end

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
